// File: rtl/secuenciador_suma_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package secuenciador_suma_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Nibble index width: max(1, ceil(log2(nibbles))).
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/secuenciador_suma_if.sv
// Requester-side handshake and operand/result bus of the sequencer.
interface secuenciador_suma_if #(
  parameter int NIBBLES = 4
);
  import secuenciador_suma_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Ci;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Co;
  logic         OV;

  modport master (
    output start, A, B, Ci,
    input  ready, busy, done, S, Co, OV
  );

  modport slave (
    input  start, A, B, Ci,
    output ready, busy, done, S, Co, OV
  );

endinterface

// File: rtl/secuenciador_suma_sumador.sv
// Combinational 4-bit adder slice shared by all nibbles of the sequencer.
module sumador_4bits
  import secuenciador_suma_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Ci,
  output logic [NIBBLE_W-1:0] S,
  output logic                Co
);

  assign {Co, S} = {1'b0, A} + {1'b0, B} + {{NIBBLE_W{1'b0}}, Ci};

endmodule

// File: rtl/secuenciador_suma.sv
// Multi-cycle W-bit adder: one 4-bit slice reused LS nibble first, carry
// held in a register between cycles.
module secuenciador_suma
  import secuenciador_suma_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  secuenciador_suma_if.slave  bus
);

  localparam int             W    = NIBBLE_W * NIBBLES;
  localparam int             IW   = idx_width(NIBBLES);
  localparam logic [IW-1:0]  LAST = IW'(NIBBLES - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic                  carry_q, carry_d;
  logic [W-1:0]          s_q, s_d;
  logic                  co_q, co_d, ov_q, ov_d;

  logic [NIBBLE_W-1:0]   add_a, add_b, add_s;
  logic                  add_co;
  logic                  accept;

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IW'(n)) begin
        add_a = a_q[n*NIBBLE_W +: NIBBLE_W];
        add_b = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  sumador_4bits u_sumador (
    .A  (add_a),
    .B  (add_b),
    .Ci (carry_q),
    .S  (add_s),
    .Co (add_co)
  );

  assign accept = bus.start && (state_q != SUMA);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE, FIN: begin
        if (accept) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.Ci;
          idx_d   = '0;
          state_d = SUMA;
        end else begin
          state_d = IDLE;
        end
      end
      SUMA: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IW'(n)) s_d[n*NIBBLE_W +: NIBBLE_W] = add_s;
        end
        carry_d = add_co;
        if (idx_q == LAST) begin
          // Carry into the MSB recovered from its sum bit, since the slice hides it.
          co_d    = add_co;
          ov_d    = (a_q[W-1] ^ b_q[W-1] ^ add_s[NIBBLE_W-1]) ^ add_co;
          state_d = FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.ready = (state_q != SUMA);
  assign bus.busy  = (state_q == SUMA);
  assign bus.done  = (state_q == FIN);
  assign bus.S     = s_q;
  assign bus.Co    = co_q;
  assign bus.OV    = ov_q;

endmodule

// File: tb/tb_secuenciador_suma.sv
// Bench for secuenciador_suma with NIBBLES=4: directed table, corner sequences
// and random adds against an integer-arithmetic reference.
module tb_secuenciador_suma;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  secuenciador_suma_if #(.NIBBLES(4)) bus ();

  secuenciador_suma #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                output logic [15:0] s, output logic co, output logic ov);
    int u;
    int sv;
    u  = int'(a) + int'(b) + int'(ci);
    s  = u[15:0];
    co = (u > 65535);
    sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
    ov = (sv > 32767) || (sv < -32768);
  endfunction

  // Call at a negedge with ready=1; returns at the negedge where done is seen.
  task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         output int lat, output logic busy1);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Ci    = ci;
    @(negedge clk);
    busy1     = bus.busy;
    bus.start = 1'b0;
    bus.A     = 16'hFFFF;
    bus.B     = 16'hFFFF;
    bus.Ci    = 1'b1;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          ndone;
    logic        busy1;
    logic [15:0] es, ra, rb;
    logic        eco, eov, rci;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = 16'h0;
    bus.B = 16'h0;
    bus.Ci = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_done",  32'(bus.done),  32'd0);
    chk("reset_S",     32'(bus.S),     32'd0);
    chk("reset_Co",    32'(bus.Co),    32'd0);
    chk("reset_OV",    32'(bus.OV),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_add(tbl[i].a, tbl[i].b, tbl[i].ci, lat, busy1);
      chk($sformatf("tbl%0d_busy", i), 32'(busy1), 32'd1);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd5);
      chk($sformatf("tbl%0d_S", i), 32'(bus.S), 32'(tbl[i].s));
      chk($sformatf("tbl%0d_Co", i), 32'(bus.Co), 32'(tbl[i].co));
      chk($sformatf("tbl%0d_OV", i), 32'(bus.OV), 32'(tbl[i].ov));
      @(negedge clk);
      chk($sformatf("tbl%0d_hold", i), 32'(bus.S), 32'(tbl[i].s));
    end

    // start pulses during SUMA must be ignored
    bus.start = 1'b1; bus.A = 16'h1111; bus.B = 16'h2222; bus.Ci = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 16'h0; bus.B = 16'h0;
    @(negedge clk);
    bus.start = 1'b1; bus.A = 16'h5555; bus.B = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 5; c < 15; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        chk("ign_done_cycle", 32'(c), 32'd5);
        chk("ign_S", 32'(bus.S), 32'h3333);
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);

    // reset in SUMA cycle 2 discards the add
    bus.start = 1'b1; bus.A = 16'hAAAA; bus.B = 16'h1111; bus.Ci = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_ready", 32'(bus.ready), 32'd1);
    chk("rstmid_busy",  32'(bus.busy),  32'd0);
    chk("rstmid_S",     32'(bus.S),     32'd0);
    chk("rstmid_Co",    32'(bus.Co),    32'd0);
    chk("rstmid_OV",    32'(bus.OV),    32'd0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("rstmid_nodone", 32'(ndone), 32'd0);
    run_add(16'hC0DE, 16'h4F21, 1'b1, lat, busy1);
    model(16'hC0DE, 16'h4F21, 1'b1, es, eco, eov);
    chk("after_rst_lat", 32'(lat), 32'd5);
    chk("after_rst_S",   32'(bus.S), 32'(es));
    chk("after_rst_Co",  32'(bus.Co), 32'(eco));
    @(negedge clk);

    // random single adds
    for (int i = 0; i < 20; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rci = 1'($urandom);
      model(ra, rb, rci, es, eco, eov);
      run_add(ra, rb, rci, lat, busy1);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd5);
      chk($sformatf("rnd%0d_S", i), 32'(bus.S), 32'(es));
      chk($sformatf("rnd%0d_Co", i), 32'(bus.Co), 32'(eco));
      chk($sformatf("rnd%0d_OV", i), 32'(bus.OV), 32'(eov));
      if (i[0]) @(negedge clk);
    end
    @(negedge clk);

    // back-to-back: start held high, new operands presented each FIN
    ra  = 16'($urandom);
    rb  = 16'($urandom);
    rci = 1'($urandom);
    bus.start = 1'b1; bus.A = ra; bus.B = rb; bus.Ci = rci;
    for (int k = 0; k < 6; k++) begin
      model(ra, rb, rci, es, eco, eov);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.done && lat < 20);
      chk($sformatf("b2b%0d_period", k), 32'(lat), 32'd5);
      chk($sformatf("b2b%0d_S", k), 32'(bus.S), 32'(es));
      chk($sformatf("b2b%0d_Co", k), 32'(bus.Co), 32'(eco));
      chk($sformatf("b2b%0d_OV", k), 32'(bus.OV), 32'(eov));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rci = 1'($urandom);
      bus.A = ra; bus.B = rb; bus.Ci = rci;
      if (k == 5) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("final_idle_ready", 32'(bus.ready), 32'd1);
    chk("final_idle_busy",  32'(bus.busy),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
